trigger_capture: RTL and testbench



---
 rtl/trigger_capture_pkg.sv | 13 +
 rtl/trigger_capture_if.sv | 24 ++
 rtl/trigger_capture_ram.sv | 21 ++
 rtl/trigger_capture.sv | 151 +++++++++++++++
 tb/tb_trigger_capture.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trigger_capture_pkg.sv
// Shared definitions for the oscilloscope trigger/capture block.
package scope_pkg;
  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    ARMED,
    POST,
    READOUT
  } state_e;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;
endpackage

// File: rtl/trigger_capture_if.sv
// Sample input, trigger controls and readout handshake of trigger_capture.
interface trigger_capture_if #(parameter int pWidth = 8);
  logic [pWidth-1:0] iData;
  logic              iData_Valid;
  logic [pWidth-1:0] iLevel;
  logic              iEdge;
  logic              iArm;
  logic [pWidth-1:0] oData;
  logic              oData_Valid;
  logic              iData_Ready;
  logic              oArmed;
  logic              oTriggered;
  logic              oDone;

  modport master (
    output iData, iData_Valid, iLevel, iEdge, iArm, iData_Ready,
    input  oData, oData_Valid, oArmed, oTriggered, oDone
  );

  modport slave (
    input  iData, iData_Valid, iLevel, iEdge, iArm, iData_Ready,
    output oData, oData_Valid, oArmed, oTriggered, oDone
  );
endinterface

// File: rtl/trigger_capture_ram.sv
// Simple dual-port record RAM: one write port, one registered read port (EBR friendly).
module capture_ram #(
  parameter int pWidth     = 8,
  parameter int pDepthLog2 = 8
) (
  input  logic                  iClk,
  input  logic                  iWe,
  input  logic [pDepthLog2-1:0] iWrAddr,
  input  logic [pWidth-1:0]     iWrData,
  input  logic                  iRe,
  input  logic [pDepthLog2-1:0] iRdAddr,
  output logic [pWidth-1:0]     oRdData
);
  logic [pWidth-1:0] mem_q [2**pDepthLog2];

  // No reset on the array or read register so the tools can map it to block RAM.
  always_ff @(posedge iClk) begin
    if (iWe) mem_q[iWrAddr] <= iWrData;
    if (iRe) oRdData <= mem_q[iRdAddr];
  end
endmodule

// File: rtl/trigger_capture.sv
// Edge/level trigger with pre-trigger ring buffer; streams the record out oldest-first.
module trigger_capture
  import scope_pkg::*;
#(
  parameter int pWidth     = 8,
  parameter int pDepthLog2 = 8,
  parameter int pPreTrig   = 64
) (
  input  logic        iClk,
  input  logic        iRst,
  trigger_capture_if.slave bus
);
  localparam int             AW      = pDepthLog2;
  localparam int             CW      = pDepthLog2 + 1;
  localparam logic [CW-1:0]  PRE_N   = CW'(pPreTrig);
  localparam logic [CW-1:0]  POST_N  = CW'((2**pDepthLog2) - pPreTrig);
  localparam logic [CW-1:0]  DEPTH_N = CW'(2**pDepthLog2);

  state_e            state_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, iss_q, xfer_q;
  logic [pWidth-1:0] prev_q, odata_q;
  logic              prev_vld_q, rv_q, ovld_q, armed_q, trig_q, done_q;

  logic              wr_en, hit, load, rd_en, xfer;
  logic [AW-1:0]     wr_ptr_inc;
  logic [CW-1:0]     cnt_inc;
  logic [pWidth-1:0] ram_rdata;

  assign wr_ptr_inc = wr_ptr_q + 1'b1;
  assign cnt_inc    = cnt_q + 1'b1;

  always_comb begin
    wr_en = bus.iData_Valid && (state_q inside {PREFILL, ARMED, POST});
    if (bus.iEdge == EDGE_FALLING)
      hit = (prev_q > bus.iLevel) && (bus.iData <= bus.iLevel);
    else
      hit = (prev_q < bus.iLevel) && (bus.iData >= bus.iLevel);
    hit   = hit && prev_vld_q;
    // rv_q marks RAM read data not yet moved to the output register; the
    // next read is issued only when that slot frees up this cycle.
    load  = rv_q && (!ovld_q || bus.iData_Ready);
    rd_en = (state_q == READOUT) && (iss_q != DEPTH_N) && (!rv_q || load);
    xfer  = ovld_q && bus.iData_Ready;
  end

  capture_ram #(.pWidth(pWidth), .pDepthLog2(pDepthLog2)) u_ram (
    .iClk    (iClk),
    .iWe     (wr_en),
    .iWrAddr (wr_ptr_q),
    .iWrData (bus.iData),
    .iRe     (rd_en),
    .iRdAddr (rd_ptr_q),
    .oRdData (ram_rdata)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      iss_q      <= '0;
      xfer_q     <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      rv_q       <= 1'b0;
      odata_q    <= '0;
      ovld_q     <= 1'b0;
      armed_q    <= 1'b0;
      trig_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_en) begin
        wr_ptr_q   <= wr_ptr_inc;
        prev_q     <= bus.iData;
        prev_vld_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (bus.iArm) begin
          state_q    <= PREFILL;
          wr_ptr_q   <= '0;
          cnt_q      <= '0;
          prev_vld_q <= 1'b0;
        end
        PREFILL: if (bus.iData_Valid) begin
          cnt_q <= cnt_inc;
          if (cnt_inc == PRE_N) begin
            state_q <= ARMED;
            armed_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ARMED: if (bus.iData_Valid && hit) begin
          armed_q <= 1'b0;
          trig_q  <= 1'b1;
          cnt_q   <= CW'(1);
          if (POST_N == CW'(1)) begin
            state_q  <= READOUT;
            rd_ptr_q <= wr_ptr_inc;
            iss_q    <= '0;
            xfer_q   <= '0;
          end else begin
            state_q <= POST;
          end
        end
        POST: if (bus.iData_Valid) begin
          cnt_q <= cnt_inc;
          // Ring is full here, so the slot after the last write is the oldest sample.
          if (cnt_inc == POST_N) begin
            state_q  <= READOUT;
            rd_ptr_q <= wr_ptr_inc;
            iss_q    <= '0;
            xfer_q   <= '0;
          end
        end
        READOUT: begin
          if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            iss_q    <= iss_q + 1'b1;
            rv_q     <= 1'b1;
          end else if (load) begin
            rv_q <= 1'b0;
          end
          if (load) begin
            odata_q <= ram_rdata;
            ovld_q  <= 1'b1;
          end else if (xfer) begin
            ovld_q <= 1'b0;
          end
          if (xfer) begin
            xfer_q <= xfer_q + 1'b1;
            if (xfer_q == DEPTH_N - CW'(1)) begin
              done_q  <= 1'b1;
              trig_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oData       = odata_q;
  assign bus.oData_Valid = ovld_q;
  assign bus.oArmed      = armed_q;
  assign bus.oTriggered  = trig_q;
  assign bus.oDone       = done_q;
endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: D=16, pPreTrig=4, level 0x80, one sample every 3 cycles.
module tb_trigger_capture;
  logic iClk = 1'b0;
  logic iRst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] rd_buf [16];
  int         rd_done;
  bit         rd_stable;
  bit         rd_tmo;

  trigger_capture_if #(.pWidth(8)) bus ();

  trigger_capture #(.pWidth(8), .pDepthLog2(4), .pPreTrig(4)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus.iData       = d;
    bus.iData_Valid = 1'b1;
    tick();
    bus.iData_Valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic arm();
    bus.iArm = 1'b1;
    tick();
    bus.iArm = 1'b0;
    tick();
  endtask

  // Collects 16 transfers plus a few trailing cycles into rd_buf / rd_done / rd_stable.
  task automatic do_readout(input bit rnd);
    int n = 0;
    int cyc = 0;
    int tail = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [7:0] pd = 8'h00;
    rd_done = 0;
    rd_stable = 1'b1;
    rd_tmo = 1'b0;
    foreach (rd_buf[i]) rd_buf[i] = 8'h00;
    while (tail < 4) begin
      bus.iData_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge iClk);
      if (pv && !pr && (!bus.oData_Valid || bus.oData !== pd)) rd_stable = 1'b0;
      if (bus.oData_Valid && bus.iData_Ready && n < 16) begin
        rd_buf[n] = bus.oData;
        n++;
      end
      if (bus.oDone) rd_done++;
      pv = bus.oData_Valid;
      pr = bus.iData_Ready;
      pd = bus.oData;
      if (n == 16) tail++;
      cyc++;
      if (cyc > 2000) begin
        rd_tmo = 1'b1;
        break;
      end
      tick();
    end
    bus.iData_Ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tests++;
    if ({bus.oData, bus.oData_Valid, bus.oArmed, bus.oTriggered, bus.oDone} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 000",
               {bus.oData, bus.oData_Valid, bus.oArmed, bus.oTriggered, bus.oDone});
    end
  endtask

  task automatic test_ramp(input string name, input bit rnd);
    bus.iEdge = 1'b0;
    bus.iData_Ready = 1'b0;
    arm();
    for (int i = 0; i < 4; i++) send(8'(i * 16));
    tests++;
    if (bus.oArmed !== 1'b1 || bus.oTriggered !== 1'b0) begin
      fails++;
      $display("FAIL %s_armed: got armed=%b trig=%b required 1/0", name, bus.oArmed, bus.oTriggered);
    end
    for (int i = 4; i < 9; i++) send(8'(i * 16));
    tests++;
    if (bus.oTriggered !== 1'b1 || bus.oArmed !== 1'b0) begin
      fails++;
      $display("FAIL %s_trig: got armed=%b trig=%b required 0/1", name, bus.oArmed, bus.oTriggered);
    end
    for (int i = 9; i < 20; i++) send(8'(i * 16));
    tests++;
    if (bus.oData_Valid !== 1'b1 || bus.oData !== 8'h40) begin
      fails++;
      $display("FAIL %s_first: got v=%b d=%h required 1/40", name, bus.oData_Valid, bus.oData);
    end
    arm();
    tests++;
    if (bus.oArmed !== 1'b0 || bus.oData_Valid !== 1'b1 || bus.oData !== 8'h40) begin
      fails++;
      $display("FAIL %s_arm_ignored: got armed=%b v=%b d=%h required 0/1/40",
               name, bus.oArmed, bus.oData_Valid, bus.oData);
    end
    do_readout(rnd);
    tests++;
    if (rd_tmo !== 1'b0) begin
      fails++;
      $display("FAIL %s_timeout: got %b required 0", name, rd_tmo);
    end
    tests++;
    if (rd_stable !== 1'b1) begin
      fails++;
      $display("FAIL %s_stable: got %b required 1", name, rd_stable);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (rd_buf[i] !== 8'((i + 4) * 16)) begin
        fails++;
        $display("FAIL %s_data[%0d]: got %h required %h", name, i, rd_buf[i], 8'((i + 4) * 16));
      end
    end
    tests++;
    if (rd_done !== 1 || bus.oTriggered !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: got done=%0d trig=%b required 1/0", name, rd_done, bus.oTriggered);
    end
  endtask

  task automatic test_level_hold();
    logic [7:0] exp [16];
    bus.iEdge = 1'b0;
    arm();
    for (int i = 0; i < 14; i++) begin
      send(8'h90);
      if (i >= 4) begin
        tests++;
        if (bus.oArmed !== 1'b1 || bus.oTriggered !== 1'b0) begin
          fails++;
          $display("FAIL hold_armed[%0d]: got armed=%b trig=%b required 1/0",
                   i, bus.oArmed, bus.oTriggered);
        end
      end
    end
    send(8'h10);
    tests++;
    if (bus.oTriggered !== 1'b0) begin
      fails++;
      $display("FAIL hold_low_no_trig: got %b required 0", bus.oTriggered);
    end
    send(8'h80);
    tests++;
    if (bus.oTriggered !== 1'b1) begin
      fails++;
      $display("FAIL hold_trig: got %b required 1", bus.oTriggered);
    end
    for (int i = 1; i <= 11; i++) send(8'(i));
    exp[0] = 8'h90; exp[1] = 8'h90; exp[2] = 8'h90; exp[3] = 8'h10; exp[4] = 8'h80;
    for (int i = 5; i < 16; i++) exp[i] = 8'(i - 4);
    do_readout(1'b0);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (rd_buf[i] !== exp[i]) begin
        fails++;
        $display("FAIL hold_data[%0d]: got %h required %h", i, rd_buf[i], exp[i]);
      end
    end
  endtask

  task automatic test_falling();
    logic [7:0] exp [16];
    bus.iEdge = 1'b1;
    arm();
    for (int i = 0; i < 5; i++) send(8'hFF);
    tests++;
    if (bus.oTriggered !== 1'b0 || bus.oArmed !== 1'b1) begin
      fails++;
      $display("FAIL fall_pre: got armed=%b trig=%b required 1/0", bus.oArmed, bus.oTriggered);
    end
    send(8'h80);
    tests++;
    if (bus.oTriggered !== 1'b1) begin
      fails++;
      $display("FAIL fall_trig: got %b required 1", bus.oTriggered);
    end
    for (int i = 0; i < 11; i++) send(8'(8'h20 + i));
    for (int i = 0; i < 4; i++) exp[i] = 8'hFF;
    exp[4] = 8'h80;
    for (int i = 5; i < 16; i++) exp[i] = 8'(8'h20 + i - 5);
    do_readout(1'b0);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (rd_buf[i] !== exp[i]) begin
        fails++;
        $display("FAIL fall_data[%0d]: got %h required %h", i, rd_buf[i], exp[i]);
      end
    end
    bus.iEdge = 1'b0;
  endtask

  task automatic test_prefill_cross();
    logic [7:0] exp [16];
    bus.iEdge = 1'b0;
    arm();
    send(8'h00); send(8'hFF); send(8'h00); send(8'h00);
    tests++;
    if (bus.oTriggered !== 1'b0 || bus.oArmed !== 1'b1) begin
      fails++;
      $display("FAIL pf_no_trig: got armed=%b trig=%b required 1/0", bus.oArmed, bus.oTriggered);
    end
    send(8'h00);
    tests++;
    if (bus.oTriggered !== 1'b0) begin
      fails++;
      $display("FAIL pf_still_armed: got trig=%b required 0", bus.oTriggered);
    end
    send(8'hFF);
    tests++;
    if (bus.oTriggered !== 1'b1) begin
      fails++;
      $display("FAIL pf_trig: got %b required 1", bus.oTriggered);
    end
    for (int i = 0; i < 11; i++) send(8'(8'h50 + i));
    exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'h00; exp[3] = 8'h00; exp[4] = 8'hFF;
    for (int i = 5; i < 16; i++) exp[i] = 8'(8'h50 + i - 5);
    do_readout(1'b0);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (rd_buf[i] !== exp[i]) begin
        fails++;
        $display("FAIL pf_data[%0d]: got %h required %h", i, rd_buf[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_in_post();
    bus.iEdge = 1'b0;
    arm();
    for (int i = 0; i < 11; i++) send(8'(i * 16));
    arm();
    tests++;
    if (bus.oTriggered !== 1'b1 || bus.oArmed !== 1'b0 || bus.oData_Valid !== 1'b0) begin
      fails++;
      $display("FAIL post_arm_ignored: got trig=%b armed=%b v=%b required 1/0/0",
               bus.oTriggered, bus.oArmed, bus.oData_Valid);
    end
    #2;
    iRst = 1'b1;
    #1;
    tests++;
    if ({bus.oData, bus.oData_Valid, bus.oArmed, bus.oTriggered, bus.oDone} !== 12'h000) begin
      fails++;
      $display("FAIL post_reset: got %h required 000",
               {bus.oData, bus.oData_Valid, bus.oArmed, bus.oTriggered, bus.oDone});
    end
    tick();
    tick();
    iRst = 1'b0;
    tick();
  endtask

  initial begin
    bus.iData       = 8'h00;
    bus.iData_Valid = 1'b0;
    bus.iLevel      = 8'h80;
    bus.iEdge       = 1'b0;
    bus.iArm        = 1'b0;
    bus.iData_Ready = 1'b0;
    tick();
    tick();
    test_reset();
    iRst = 1'b0;
    tick();
    test_ramp("ramp", 1'b0);
    test_level_hold();
    test_falling();
    test_ramp("bp", 1'b1);
    test_prefill_cross();
    test_reset_in_post();
    test_ramp("after_rst", 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
